jk_bank_ctrl: RTL

- Command controller and two-port arbiter for a bank of WIDTH external jk_ff flip-flops.
- Two requesters issue per-bit hold/clear/set/toggle commands over valid/ready handshakes.
- The block arbitrates round-robin, drives a one-cycle J/K pulse onto the selected bit, then returns the bit's new value.
- It also clears the bank after reset, because the flip-flops have no reset of their own.

---
 rtl/jk_bank_ctrl_if.sv | 31 +++
 rtl/jk_bank_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/jk_bank_ctrl_if.sv
// Request/response bus for jk_bank_ctrl: two command requesters plus the shared response strobe.
interface jk_bank_ctrl_if #(
    parameter int unsigned IDX_W = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [IDX_W-1:0] req0_idx;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [IDX_W-1:0] req1_idx;
    logic             rsp_valid;
    logic             rsp_id;
    logic             rsp_q;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_idx,
        input  req1_valid, req1_op, req1_idx,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_q, rsp_err
    );

    modport master (
        output req0_valid, req0_op, req0_idx,
        output req1_valid, req1_op, req1_idx,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_q, rsp_err
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Round-robin command controller for a bank of reset-less JK flip-flops; clears the bank after
// reset, then drives one-cycle J/K pulses per accepted command and returns the new bit value.
module jk_bank_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    jk_bank_ctrl_if.slave    bus,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    input  logic [WIDTH-1:0] ff_q,
    output logic             busy
);

    typedef enum logic [1:0] {StInit, StIdle, StDrive, StResp} state_e;

    state_e           state_q;
    logic             last_grant_q;
    logic [1:0]       op_q;
    logic [IDX_W-1:0] idx_q;
    logic             id_q;
    logic             err_q;

    logic             grant0;
    logic             grant1;
    logic [1:0]       cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic [WIDTH-1:0] sel;

    // When both are valid, the side that did not win last time gets the grant.
    always_comb begin
        grant0  = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1  = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        cmd_op  = grant1 ? bus.req1_op  : bus.req0_op;
        cmd_idx = grant1 ? bus.req1_idx : bus.req0_idx;
        bus.req0_ready = (state_q == StIdle) && grant0;
        bus.req1_ready = (state_q == StIdle) && grant1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StInit;
            last_grant_q <= 1'b1;
            op_q         <= 2'b00;
            idx_q        <= '0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: state_q <= StIdle;
                StIdle: begin
                    if (grant0 || grant1) begin
                        op_q         <= cmd_op;
                        idx_q        <= cmd_idx;
                        id_q         <= grant1;
                        err_q        <= (32'(cmd_idx) >= WIDTH);
                        last_grant_q <= grant1;
                        state_q      <= StDrive;
                    end
                end
                StDrive: state_q <= StResp;
                StResp:  state_q <= StIdle;
                default: state_q <= StInit;
            endcase
        end
    end

    // One-hot of the captured target bit; empty for out-of-range indices.
    always_comb begin
        sel  = err_q ? '0 : (WIDTH'(1) << idx_q);
        jk_j = '0;
        jk_k = '0;
        if (!rst) begin
            if (state_q == StInit) begin
                jk_k = '1;
            end else if (state_q == StDrive) begin
                jk_j = op_q[1] ? sel : '0;
                jk_k = op_q[0] ? sel : '0;
            end
        end
    end

    always_comb begin
        bus.rsp_valid = (state_q == StResp);
        bus.rsp_id    = bus.rsp_valid && id_q;
        bus.rsp_q     = bus.rsp_valid && (|(ff_q & sel));
        bus.rsp_err   = bus.rsp_valid && err_q;
        busy          = (state_q != StIdle);
    end

endmodule
